// File: rtl/mips_regfile_pkg.sv
// Shared definitions for the MIPS architectural register file.
package mips_regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] word_t;

  // Architecturally significant register indices.
  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_SP   = 5'd29;
  localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: selects a stored entry, forces
// $0 to zero and optionally forwards a write that is being presented in the
// same cycle.
module regfile_read_port
  import mips_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic [DATA_W-1:0] regs_i [(1 << ADDR_W)],
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              fwd_en,
  input  logic [ADDR_W-1:0] fwd_addr,
  input  logic [DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0] rd_data
);

  logic addr_is_zero;
  logic fwd_hit;

  assign addr_is_zero = (rd_addr == ADDR_W'(REG_ZERO));
  assign fwd_hit      = BYPASS && fwd_en && (fwd_addr == rd_addr);

  // $0 always wins, then the forwarded write, then the stored entry.
  always_comb begin
    rd_data = '0;
    if (!addr_is_zero) begin
      if (fwd_hit) begin
        rd_data = fwd_data;
      end else begin
        rd_data = regs_i[rd_addr];
      end
    end
  end

endmodule

// File: rtl/regfile_wb_sink.sv
// Architectural register file at the end of the writeback path: 32-entry
// storage, two operand read ports with optional forwarding, the multicycle
// A/B operand latches, write acknowledge/drop pulses and a debug read port.
module regfile_wb_sink
  import mips_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              ab_en,
  output logic [DATA_W-1:0] a_q,
  output logic [DATA_W-1:0] b_q,
  output logic              wr_ack,
  output logic              wr_drop,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] a_reg_q, a_reg_d;
  logic [DATA_W-1:0] b_reg_q, b_reg_d;
  logic              wr_ack_q, wr_ack_d;
  logic              wr_drop_q, wr_drop_d;

  logic wr_to_zero;
  logic wr_commit;
  logic fwd_en;

  assign wr_to_zero = (wr_addr == ADDR_W'(REG_ZERO));
  assign wr_commit  = reg_write && !wr_to_zero;
  // A write presented while reset is asserted can never commit, so it is
  // not forwarded either; every output then reads zero during reset.
  assign fwd_en     = reg_write && rst_n;

  // Next storage contents: apply the committed write, keep $0 hard-wired.
  always_comb begin
    regs_d = regs_q;
    if (wr_commit) begin
      regs_d[wr_addr] = wr_data;
    end
    regs_d[0] = '0;
  end

  // Storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port_a (
    .regs_i   (regs_q),
    .rd_addr  (rs_addr),
    .fwd_en   (fwd_en),
    .fwd_addr (wr_addr),
    .fwd_data (wr_data),
    .rd_data  (rd_data_a)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port_b (
    .regs_i   (regs_q),
    .rd_addr  (rt_addr),
    .fwd_en   (fwd_en),
    .fwd_addr (wr_addr),
    .fwd_data (wr_data),
    .rd_data  (rd_data_b)
  );

  // Debug view shows the stored value only, so forwarding is tied off.
  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (1'b0)
  ) u_port_dbg (
    .regs_i   (regs_q),
    .rd_addr  (dbg_addr),
    .fwd_en   (1'b0),
    .fwd_addr ('0),
    .fwd_data ('0),
    .rd_data  (dbg_data)
  );

  // Operand latches capture the port outputs (forwarded value included) on ab_en.
  always_comb begin
    a_reg_d   = a_reg_q;
    b_reg_d   = b_reg_q;
    wr_ack_d  = wr_commit;
    wr_drop_d = reg_write && wr_to_zero;
    if (ab_en) begin
      a_reg_d = rd_data_a;
      b_reg_d = rd_data_b;
    end
  end

  // Operand latches and one-cycle write status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg_q   <= '0;
      b_reg_q   <= '0;
      wr_ack_q  <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      a_reg_q   <= a_reg_d;
      b_reg_q   <= b_reg_d;
      wr_ack_q  <= wr_ack_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  assign a_q     = a_reg_q;
  assign b_q     = b_reg_q;
  assign wr_ack  = wr_ack_q;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Scoreboard bench for regfile_wb_sink: one instance with forwarding, one
// without, driven by the same directed and random stimulus. The stimulus
// process keeps an abstract register-file model and queues the outputs
// expected at the next sample point; a monitor compares on each falling edge.
module tb_regfile_wb_sink;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          reg_write;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic          ab_en;
  logic [AW-1:0] dbg_addr;

  logic [DW-1:0] rd_a_1, rd_b_1, a_1, b_1, dbg_1;
  logic [DW-1:0] rd_a_0, rd_b_0, a_0, b_0, dbg_0;
  logic          ack_1, drop_1, ack_0, drop_0;

  always #5 clk = ~clk;

  regfile_wb_sink #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .wr_addr(wr_addr),
    .wr_data(wr_data), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_data_a(rd_a_1), .rd_data_b(rd_b_1), .ab_en(ab_en),
    .a_q(a_1), .b_q(b_1), .wr_ack(ack_1), .wr_drop(drop_1),
    .dbg_addr(dbg_addr), .dbg_data(dbg_1)
  );

  regfile_wb_sink #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .wr_addr(wr_addr),
    .wr_data(wr_data), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_data_a(rd_a_0), .rd_data_b(rd_b_0), .ab_en(ab_en),
    .a_q(a_0), .b_q(b_0), .wr_ack(ack_0), .wr_drop(drop_0),
    .dbg_addr(dbg_addr), .dbg_data(dbg_0)
  );

  typedef struct {
    int          id;
    logic [31:0] rd_a1, rd_b1, rd_a0, rd_b0;
    logic [31:0] a1, b1, a0, b0;
    logic [31:0] dbg;
    logic        ack, drop;
  } exp_t;

  exp_t exp_q[$];
  int   checks_total = 0;
  int   checks_pass  = 0;
  int   txn_id       = 0;

  // Reference model state
  logic [31:0] m_mem [32];
  logic [31:0] m_a1, m_b1, m_a0, m_b0;
  logic        m_ack, m_drop;

  function automatic logic [31:0] m_read(input int addr, input bit byp);
    if (addr == 0) return 32'h0;
    if (byp && reg_write && rst_n && (int'(wr_addr) == addr)) return wr_data;
    return m_mem[addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    m_a1 = 0; m_b1 = 0; m_a0 = 0; m_b0 = 0;
    m_ack = 0; m_drop = 0;
  endtask

  // What a rising edge does, given the inputs held across it.
  task automatic model_edge();
    logic [31:0] na1, nb1, na0, nb0;
    if (!rst_n) begin
      model_reset();
    end else begin
      na1 = ab_en ? m_read(int'(rs_addr), 1'b1) : m_a1;
      nb1 = ab_en ? m_read(int'(rt_addr), 1'b1) : m_b1;
      na0 = ab_en ? m_read(int'(rs_addr), 1'b0) : m_a0;
      nb0 = ab_en ? m_read(int'(rt_addr), 1'b0) : m_b0;
      m_a1 = na1; m_b1 = nb1; m_a0 = na0; m_b0 = nb0;
      m_ack  = reg_write && (wr_addr != 0);
      m_drop = reg_write && (wr_addr == 0);
      if (m_ack) m_mem[wr_addr] = wr_data;
    end
  endtask

  // One transaction: account for the edge, drive new inputs, queue expectation.
  task automatic cycle(input bit rst, input bit we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] rs,
                       input logic [4:0] rt, input bit ab, input logic [4:0] dbg);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    rst_n = rst; reg_write = we; wr_addr = wa; wr_data = wd;
    rs_addr = rs; rt_addr = rt; ab_en = ab; dbg_addr = dbg;
    if (!rst) model_reset();
    e.id    = txn_id;
    e.rd_a1 = m_read(int'(rs), 1'b1);
    e.rd_b1 = m_read(int'(rt), 1'b1);
    e.rd_a0 = m_read(int'(rs), 1'b0);
    e.rd_b0 = m_read(int'(rt), 1'b0);
    e.a1 = m_a1; e.b1 = m_b1; e.a0 = m_a0; e.b0 = m_b0;
    e.dbg  = m_read(int'(dbg), 1'b0);
    e.ack  = m_ack;
    e.drop = m_drop;
    exp_q.push_back(e);
    txn_id++;
  endtask

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    checks_total++;
    if (act !== exp)
      $display("FAIL txn %0d %s: got %h expected %h", id, name, act, exp);
    else
      checks_pass++;
  endtask

  // Monitor: compare DUT outputs against the queued expectation each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_data_a byp",   e.id, rd_a_1, e.rd_a1);
        chk("rd_data_b byp",   e.id, rd_b_1, e.rd_b1);
        chk("rd_data_a nobyp", e.id, rd_a_0, e.rd_a0);
        chk("rd_data_b nobyp", e.id, rd_b_0, e.rd_b0);
        chk("a_q byp",         e.id, a_1, e.a1);
        chk("b_q byp",         e.id, b_1, e.b1);
        chk("a_q nobyp",       e.id, a_0, e.a0);
        chk("b_q nobyp",       e.id, b_0, e.b0);
        chk("dbg_data byp",    e.id, dbg_1, e.dbg);
        chk("dbg_data nobyp",  e.id, dbg_0, e.dbg);
        chk("wr_ack byp",      e.id, {31'b0, ack_1},  {31'b0, e.ack});
        chk("wr_drop byp",     e.id, {31'b0, drop_1}, {31'b0, e.drop});
        chk("wr_ack nobyp",    e.id, {31'b0, ack_0},  {31'b0, e.ack});
        chk("wr_drop nobyp",   e.id, {31'b0, drop_0}, {31'b0, e.drop});
        $display("txn %0d rst_n=%0b we=%0b wa=%0d rs=%0d rt=%0d ab=%0b rd_a=%h a_q=%h ack=%0b drop=%0b",
                 e.id, rst_n, reg_write, wr_addr, rs_addr, rt_addr, ab_en,
                 rd_a_1, a_1, ack_1, drop_1);
      end
    end
  end

  // Watchdog: the run must never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit rst_r;
    logic [4:0] wa, rs, rt, dg;
    rst_n = 1'b0; reg_write = 1'b0; wr_addr = '0; wr_data = '0;
    rs_addr = '0; rt_addr = '0; ab_en = 1'b0; dbg_addr = '0;
    model_reset();

    // Held in reset, even with a write presented.
    cycle(0, 1, 5'd3, 32'hAAAA_5555, 5'd3, 5'd3, 1, 5'd3);
    cycle(0, 0, 5'd0, 32'h0, 5'd31, 5'd1, 1, 5'd31);
    // Released, no writes: every address reads zero.
    for (int i = 0; i < 32; i++)
      cycle(1, 0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1, 5'(i));

    // Link write to $31.
    cycle(1, 1, 5'd31, 32'h0040_0008, 5'd31, 5'd31, 0, 5'd31);
    cycle(1, 0, 5'd0,  32'h0,         5'd31, 5'd0,  0, 5'd31);
    cycle(1, 0, 5'd0,  32'h0,         5'd31, 5'd31, 0, 5'd31);

    // Write to $0 is dropped.
    cycle(1, 1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, 1, 5'd0);
    cycle(1, 0, 5'd0, 32'h0,         5'd0, 5'd0, 1, 5'd0);
    cycle(1, 0, 5'd0, 32'h0,         5'd0, 5'd0, 0, 5'd0);

    // Same-cycle write and latch capture on $5.
    cycle(1, 1, 5'd5, 32'h11, 5'd1, 5'd2, 0, 5'd5);
    cycle(1, 1, 5'd5, 32'h22, 5'd5, 5'd5, 1, 5'd5);
    cycle(1, 0, 5'd0, 32'h0,  5'd5, 5'd5, 0, 5'd5);

    // Latch hold while the source register keeps changing.
    cycle(1, 1, 5'd6, 32'h33, 5'd0, 5'd0, 0, 5'd6);
    cycle(1, 0, 5'd0, 32'h0,  5'd6, 5'd6, 1, 5'd6);
    cycle(1, 1, 5'd6, 32'h44, 5'd6, 5'd6, 0, 5'd6);
    cycle(1, 1, 5'd6, 32'h55, 5'd6, 5'd6, 0, 5'd6);
    cycle(1, 0, 5'd0, 32'h0,  5'd6, 5'd6, 1, 5'd6);
    cycle(1, 0, 5'd0, 32'h0,  5'd6, 5'd6, 0, 5'd6);

    // Back-to-back writes keep wr_ack high.
    for (int i = 1; i <= 4; i++)
      cycle(1, 1, 5'(i), 32'h100 + 32'(i), 5'(i), 5'(i - 1), 0, 5'(i));
    cycle(1, 0, 5'd0, 32'h0, 5'd4, 5'd3, 0, 5'd2);

    // Asynchronous reset between edges with a write pending.
    cycle(1, 1, 5'd7, 32'h77, 5'd7, 5'd7, 1, 5'd7);
    cycle(0, 1, 5'd7, 32'h99, 5'd7, 5'd7, 1, 5'd7);
    cycle(0, 0, 5'd0, 32'h0,  5'd7, 5'd7, 0, 5'd7);
    cycle(1, 0, 5'd0, 32'h0,  5'd7, 5'd7, 1, 5'd7);
    cycle(1, 0, 5'd0, 32'h0,  5'd7, 5'd7, 0, 5'd7);

    // Randomized traffic focused on a few registers to provoke collisions.
    for (int n = 0; n < 300; n++) begin
      rst_r = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 3) == 0) begin
        wa = 5'($urandom_range(0, 31)); rs = 5'($urandom_range(0, 31));
        rt = 5'($urandom_range(0, 31)); dg = 5'($urandom_range(0, 31));
      end else begin
        wa = 5'($urandom_range(0, 7)); rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7)); dg = 5'($urandom_range(0, 7));
      end
      cycle(rst_r, 1'($urandom_range(0, 1)), wa, $urandom, rs, rt,
            1'($urandom_range(0, 1)), dg);
    end

    // Let the monitor consume the last expectation.
    @(negedge clk);
    #1;
    chk("scoreboard drained", -1, 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
